id_pipe_stage_v2: RTL and testbench

Parametrised second-generation MIPS-32 decode stage. It decodes the instruction, reads a write-through register file, and resolves beq/j inside decode. It detects load-use and branch-operand hazards itself and raises a stall to fetch. Its outputs are registered internally as the ID/EX pipeline register, with bubble insertion and flush.

---
 rtl/id_pipe_stage_v2.sv | 194 +++++++++++++++++++
 tb/tb_id_pipe_stage_v2.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_stage_v2.sv
// MIPS-32 decode stage: control decode, write-through register file,
// in-decode beq/j resolution, hazard stall and the ID/EX pipeline register.
module id_pipe_stage_v2 #(
    parameter int PC_WIDTH       = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PC_WIDTH-1:0]       pc_plus4,
    input  logic [31:0]               instr,
    input  logic                      instr_valid,
    input  logic                      flush,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_dest,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_dest,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      stall,
    output logic                      branch_taken,
    output logic [PC_WIDTH-1:0]       branch_address,
    output logic                      jump,
    output logic [PC_WIDTH-1:0]       jump_address,
    output logic                      idex_valid,
    output logic [DATA_WIDTH-1:0]     idex_reg1,
    output logic [DATA_WIDTH-1:0]     idex_reg2,
    output logic [DATA_WIDTH-1:0]     idex_imm,
    output logic [REG_ADDR_WIDTH-1:0] idex_rs,
    output logic [REG_ADDR_WIDTH-1:0] idex_rt,
    output logic [REG_ADDR_WIDTH-1:0] idex_dest,
    output logic                      idex_mem_to_reg,
    output logic [1:0]                idex_alu_op,
    output logic                      idex_mem_read,
    output logic                      idex_mem_write,
    output logic                      idex_alu_src,
    output logic                      idex_reg_write
);

    localparam int NREG = 1 << REG_ADDR_WIDTH;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [5:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs, rt, rd, dest;
    logic [DATA_WIDTH-1:0]     imm, rs_val, rt_val;

    logic reg_dst, alu_src, mem_to_reg, mem_read, mem_write;
    logic reg_write, is_beq, is_j;
    logic [1:0] alu_op;
    logic rs_used, rt_used, load_use, br_haz, ex_hit, mem_hit;
    logic valid_d;

    logic [DATA_WIDTH-1:0] rf_q [NREG];

    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     reg1_q, reg2_q, imm_q;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rt_q, dest_q;
    logic                      mem_to_reg_q, mem_read_q, mem_write_q;
    logic                      alu_src_q, reg_write_q;
    logic [1:0]                alu_op_q;

    assign opcode = instr[31:26];
    assign rs     = REG_ADDR_WIDTH'(instr[25:21]);
    assign rt     = REG_ADDR_WIDTH'(instr[20:16]);
    assign rd     = REG_ADDR_WIDTH'(instr[15:11]);
    assign imm    = DATA_WIDTH'($signed(instr[15:0]));
    assign dest   = reg_dst ? rd : rt;

    always_comb begin
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        alu_op     = 2'b00;
        case (opcode)
            OP_R: begin
                reg_dst   = 1'b1;
                alu_op    = 2'b10;
                reg_write = 1'b1;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                mem_read   = 1'b1;
                reg_write  = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                is_beq = 1'b1;
                alu_op = 2'b01;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_J:    is_j = 1'b1;
            default: ;
        endcase
    end

    // Same-cycle writeback is forwarded so decode never sees a stale value.
    assign rs_val = (rs == '0) ? '0 :
                    (wb_reg_write && wb_dest == rs) ? wb_data : rf_q[rs];
    assign rt_val = (rt == '0) ? '0 :
                    (wb_reg_write && wb_dest == rt) ? wb_data : rf_q[rt];

    assign rs_used = (opcode != OP_J);
    assign rt_used = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);

    assign load_use = instr_valid && valid_q && mem_read_q && dest_q != '0 &&
                      ((rs_used && dest_q == rs) || (rt_used && dest_q == rt));

    assign ex_hit  = valid_q && reg_write_q && dest_q != '0 &&
                     (dest_q == rs || dest_q == rt);
    assign mem_hit = exmem_reg_write && exmem_dest != '0 &&
                     (exmem_dest == rs || exmem_dest == rt);
    assign br_haz  = instr_valid && is_beq && (ex_hit || mem_hit);

    assign stall          = load_use || br_haz;
    assign branch_taken   = is_beq && instr_valid && !stall && (rs_val == rt_val);
    assign branch_address = pc_plus4 + PC_WIDTH'(imm << 2);
    assign jump           = is_j && instr_valid && !stall;
    assign jump_address   = PC_WIDTH'({instr[25:0], 2'b00});

    assign valid_d = instr_valid && !flush && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_reg_write && wb_dest != '0) begin
            rf_q[wb_dest] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            reg1_q       <= '0;
            reg2_q       <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            dest_q       <= '0;
            mem_to_reg_q <= 1'b0;
            alu_op_q     <= 2'b00;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            // Data fields are don't-care in a bubble; only control is gated.
            valid_q      <= valid_d;
            reg1_q       <= rs_val;
            reg2_q       <= rt_val;
            imm_q        <= imm;
            rs_q         <= rs;
            rt_q         <= rt;
            dest_q       <= dest;
            mem_to_reg_q <= mem_to_reg && valid_d;
            alu_op_q     <= valid_d ? alu_op : 2'b00;
            mem_read_q   <= mem_read && valid_d;
            mem_write_q  <= mem_write && valid_d;
            alu_src_q    <= alu_src && valid_d;
            reg_write_q  <= reg_write && valid_d;
        end
    end

    assign idex_valid      = valid_q;
    assign idex_reg1       = reg1_q;
    assign idex_reg2       = reg2_q;
    assign idex_imm        = imm_q;
    assign idex_rs         = rs_q;
    assign idex_rt         = rt_q;
    assign idex_dest       = dest_q;
    assign idex_mem_to_reg = mem_to_reg_q;
    assign idex_alu_op     = alu_op_q;
    assign idex_mem_read   = mem_read_q;
    assign idex_mem_write  = mem_write_q;
    assign idex_alu_src    = alu_src_q;
    assign idex_reg_write  = reg_write_q;

endmodule

// File: tb/tb_id_pipe_stage_v2.sv
// Bench for id_pipe_stage_v2: directed scenarios plus random instruction
// streams checked against a cycle-level behavioural model.
module tb_id_pipe_stage_v2;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pc_plus4;
    logic [31:0] instr;
    logic        instr_valid, flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_dest;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        stall, branch_taken, jump;
    logic [9:0]  branch_address, jump_address;
    logic        idex_valid;
    logic [31:0] idex_reg1, idex_reg2, idex_imm;
    logic [4:0]  idex_rs, idex_rt, idex_dest;
    logic        idex_mem_to_reg, idex_mem_read, idex_mem_write;
    logic        idex_alu_src, idex_reg_write;
    logic [1:0]  idex_alu_op;

    id_pipe_stage_v2 dut (
        .clk(clk), .reset(reset), .pc_plus4(pc_plus4), .instr(instr),
        .instr_valid(instr_valid), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
        .stall(stall), .branch_taken(branch_taken),
        .branch_address(branch_address), .jump(jump),
        .jump_address(jump_address), .idex_valid(idex_valid),
        .idex_reg1(idex_reg1), .idex_reg2(idex_reg2), .idex_imm(idex_imm),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_dest(idex_dest),
        .idex_mem_to_reg(idex_mem_to_reg), .idex_alu_op(idex_alu_op),
        .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
        .idex_alu_src(idex_alu_src), .idex_reg_write(idex_reg_write)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] reg1, reg2, imm;
        logic [4:0]  rs, rt, dest;
        logic        m2r;
        logic [1:0]  aluop;
        logic        mr, mw, asrc, rw;
    } idex_m_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_rf [32];
    idex_m_t     m, e_dec;
    logic        e_stall, e_bt, e_j;
    logic [9:0]  e_ba, e_ja;
    logic        last_stall, last_bt, last_j;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdv(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_reg_write && wb_dest == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] r_ins(input int d, input int s, input int t);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int s,
                                          input int t, input int imm);
        return {op, 5'(s), 5'(t), 16'(imm)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m = '0;
    endtask

    task automatic model_comb();
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic is_beq, is_j, rdst, use_rt, lu, bh;
        int sx;
        op = instr[31:26];
        rs = instr[25:21];
        rt = instr[20:16];
        is_beq = 0; is_j = 0; rdst = 0;
        e_dec = '0;
        e_dec.valid = 1;
        e_dec.rs = rs;
        e_dec.rt = rt;
        sx = int'($signed(instr[15:0]));
        e_dec.imm = 32'(sx);
        e_dec.reg1 = rdv(rs);
        e_dec.reg2 = rdv(rt);
        case (op)
            6'h00: begin rdst = 1; e_dec.aluop = 2; e_dec.rw = 1; end
            6'h23: begin e_dec.asrc = 1; e_dec.m2r = 1; e_dec.mr = 1; e_dec.rw = 1; end
            6'h2b: begin e_dec.asrc = 1; e_dec.mw = 1; end
            6'h04: begin is_beq = 1; e_dec.aluop = 1; end
            6'h08: begin e_dec.asrc = 1; e_dec.rw = 1; end
            6'h02: is_j = 1;
            default: ;
        endcase
        e_dec.dest = rdst ? instr[15:11] : rt;
        use_rt = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
        lu = instr_valid && m.valid && m.mr && m.dest != 0 &&
             ((!is_j && m.dest == rs) || (use_rt && m.dest == rt));
        bh = instr_valid && is_beq &&
             ((m.valid && m.rw && m.dest != 0 && (m.dest == rs || m.dest == rt)) ||
              (exmem_reg_write && exmem_dest != 0 &&
               (exmem_dest == rs || exmem_dest == rt)));
        e_stall = lu || bh;
        e_bt = is_beq && instr_valid && !e_stall && (e_dec.reg1 == e_dec.reg2);
        e_j  = is_j && instr_valid && !e_stall;
        e_ba = 10'(int'(pc_plus4) + sx * 4);
        e_ja = 10'(32'(instr[25:0]) * 4);
    endtask

    task automatic model_seq();
        if (flush || e_stall || !instr_valid) begin
            m.valid = 0; m.m2r = 0; m.aluop = 0;
            m.mr = 0; m.mw = 0; m.asrc = 0; m.rw = 0;
        end else begin
            m = e_dec;
        end
        if (wb_reg_write && wb_dest != 0) m_rf[wb_dest] = wb_data;
    endtask

    task automatic check_idex();
        check("idex_valid", 64'(idex_valid), 64'(m.valid));
        check("idex_m2r", 64'(idex_mem_to_reg), 64'(m.m2r));
        check("idex_aluop", 64'(idex_alu_op), 64'(m.aluop));
        check("idex_mr", 64'(idex_mem_read), 64'(m.mr));
        check("idex_mw", 64'(idex_mem_write), 64'(m.mw));
        check("idex_asrc", 64'(idex_alu_src), 64'(m.asrc));
        check("idex_rw", 64'(idex_reg_write), 64'(m.rw));
        if (m.valid) begin
            check("idex_reg1", 64'(idex_reg1), 64'(m.reg1));
            check("idex_reg2", 64'(idex_reg2), 64'(m.reg2));
            check("idex_imm", 64'(idex_imm), 64'(m.imm));
            check("idex_rs", 64'(idex_rs), 64'(m.rs));
            check("idex_rt", 64'(idex_rt), 64'(m.rt));
            check("idex_dest", 64'(idex_dest), 64'(m.dest));
        end
    endtask

    task automatic step();
        #1;
        model_comb();
        last_stall = stall;
        last_bt    = branch_taken;
        last_j     = jump;
        check("stall", 64'(stall), 64'(e_stall));
        check("br_taken", 64'(branch_taken), 64'(e_bt));
        check("br_addr", 64'(branch_address), 64'(e_ba));
        check("jump", 64'(jump), 64'(e_j));
        check("jump_addr", 64'(jump_address), 64'(e_ja));
        @(posedge clk);
        model_seq();
        #1;
        check_idex();
        @(negedge clk);
    endtask

    task automatic set_idle();
        instr = 32'h0; instr_valid = 1; flush = 0;
        exmem_reg_write = 0; exmem_dest = 0;
        wb_reg_write = 0; wb_dest = 0; wb_data = 0;
        pc_plus4 = 10'h0;
    endtask

    initial begin
        logic [5:0] ops [7];
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h0d};
        reset = 1;
        set_idle();
        instr_valid = 0;
        model_reset();
        @(negedge clk);
        check("rst_valid", 64'(idex_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_rw", 64'(idex_reg_write), 64'd0);
        check("rst_reg1", 64'(idex_reg1), 64'd0);
        reset = 0;

        // writeback bypass into decode
        set_idle();
        instr = r_ins(6, 5, 0);
        wb_reg_write = 1; wb_dest = 5; wb_data = 32'h1234;
        step();
        check("t1_reg1", 64'(idex_reg1), 64'h1234);
        check("t1_dest", 64'(idex_dest), 64'd6);
        check("t1_rw", 64'(idex_reg_write), 64'd1);
        check("t1_aluop", 64'(idex_alu_op), 64'd2);

        // load-use: one stall, one bubble
        set_idle();
        instr = i_ins(6'h23, 1, 2, 4);
        step();
        instr = r_ins(3, 2, 4);
        step();
        check("lu_stall", 64'(last_stall), 64'd1);
        check("lu_bubble", 64'(idex_valid), 64'd0);
        step();
        check("lu_release", 64'(last_stall), 64'd0);
        check("lu_issue", 64'(idex_valid), 64'd1);
        check("lu_dest", 64'(idex_dest), 64'd3);

        // beq behind an ALU producer: EX then MEM stall
        set_idle();
        instr = r_ins(7, 1, 2);
        step();
        instr = i_ins(6'h04, 7, 0, 8);
        pc_plus4 = 10'h040;
        step();
        check("bh_stall_ex", 64'(last_stall), 64'd1);
        exmem_reg_write = 1; exmem_dest = 7;
        step();
        check("bh_stall_mem", 64'(last_stall), 64'd1);
        exmem_reg_write = 0;
        wb_reg_write = 1; wb_dest = 7; wb_data = 32'h0;
        step();
        check("bh_release", 64'(last_stall), 64'd0);
        check("bh_taken", 64'(last_bt), 64'd1);
        check("bh_addr", 64'(branch_address), 64'h060);

        // jump
        set_idle();
        instr = {6'b000010, 26'h10};
        step();
        check("j_jump", 64'(last_j), 64'd1);
        check("j_stall", 64'(last_stall), 64'd0);
        check("j_addr", 64'(jump_address), 64'h040);

        // flush together with load-use stall
        set_idle();
        instr = i_ins(6'h23, 1, 2, 4);
        step();
        instr = r_ins(3, 2, 4);
        flush = 1;
        step();
        check("fl_stall", 64'(last_stall), 64'd1);
        check("fl_bubble", 64'(idex_valid), 64'd0);

        // async reset in the middle of a stall
        set_idle();
        instr = i_ins(6'h23, 1, 2, 4);
        step();
        instr = r_ins(3, 2, 4);
        #1;
        check("mr_pre_stall", 64'(stall), 64'd1);
        reset = 1;
        #1;
        model_reset();
        check("mr_stall", 64'(stall), 64'd0);
        check("mr_valid", 64'(idex_valid), 64'd0);
        check("mr_mr", 64'(idex_mem_read), 64'd0);
        check("mr_rw", 64'(idex_reg_write), 64'd0);
        check("mr_dest", 64'(idex_dest), 64'd0);
        @(negedge clk);
        reset = 0;

        // $0 is hardwired zero
        set_idle();
        instr = r_ins(1, 0, 0);
        wb_reg_write = 1; wb_dest = 0; wb_data = 32'hFFFF;
        step();
        check("z_bypass", 64'(idex_reg1), 64'd0);
        wb_reg_write = 0;
        step();
        check("z_read", 64'(idex_reg1), 64'd0);

        for (int n = 0; n < 600; n++) begin
            instr = {ops[$urandom_range(6)], 5'($urandom_range(7)),
                     5'($urandom_range(7)), 5'($urandom_range(7)),
                     11'($urandom)};
            if ($urandom_range(3) == 0) instr[25:0] = 26'($urandom);
            instr_valid     = ($urandom_range(9) != 0);
            flush           = ($urandom_range(9) == 0);
            exmem_reg_write = ($urandom_range(3) == 0);
            exmem_dest      = 5'($urandom_range(7));
            wb_reg_write    = ($urandom_range(1) == 0);
            wb_dest         = 5'($urandom_range(7));
            wb_data         = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
            pc_plus4        = 10'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
